// File: rtl/tft_spi_arbiter.sv
// tft_spi_arbiter: shares one SPI transmitter between init, scene and player requesters.
module tft_spi_arbiter #(
    parameter int MAX_HOLD = 65535,
    parameter int HOLD_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [2:0] dc_in,
    input  logic [2:0] tx_in,
    input  logic       spi_busy,
    output logic [2:0] gnt,
    output logic [7:0] spi_data,
    output logic       spi_dc,
    output logic       spi_transmit,
    output logic       init_done,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN, GAP} state_t;
    state_t state, state_nx;
    logic [2:0] owner, winner, elig, mask;
    logic [HOLD_W-1:0] hold_cnt;
    logic ptr, owner_req, granting, revoke, owning;
    always_comb begin
        owning    = state == GRANT;
        elig      = req & ~mask & (init_done ? 3'b111 : 3'b001);
        owner_req = |(req & owner);
        // ptr = 0 prefers scene, ptr = 1 prefers player
        winner    = elig[0] ? 3'b001 :
                    (elig[1] && elig[2]) ? (ptr ? 3'b100 : 3'b010) : (elig & 3'b110);
        granting  = state == IDLE && |elig;
        revoke    = owning && MAX_HOLD != 0 && owner_req && hold_cnt == HOLD_W'(MAX_HOLD - 1);
        state_nx  = state;
        case (state)
            IDLE:    state_nx = granting ? GRANT : IDLE;
            GRANT:   state_nx = (!owner_req || revoke) ? DRAIN : GRANT;
            DRAIN:   state_nx = spi_busy ? DRAIN : GAP;
            default: state_nx = IDLE;
        endcase
        gnt          = owning ? owner : 3'b000;
        spi_transmit = owning && |(tx_in & owner);
        spi_dc       = owning && |(dc_in & owner);
        spi_data     = !owning ? 8'h00 : owner[0] ? data0 : owner[1] ? data1 : data2;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 3'b000;
            ptr       <= 1'b0;
            mask      <= 3'b000;
            hold_cnt  <= '0;
            init_done <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state   <= state_nx;
            timeout <= revoke;
            mask    <= (mask & req) | (revoke ? owner : 3'b000);
            if (granting) begin
                owner    <= winner;
                hold_cnt <= '0;
                if (winner[1] || winner[2]) ptr <= winner[1];
            end else if (owning && hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (owning && !owner_req && owner[0]) init_done <= 1'b1;
        end
    end
endmodule

// File: doc/tft_spi_arbiter.md
TFT_SPI_ARBITER -- requirements
Module: tft_spi_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 65535, maximum grant duration in clk cycles (0 = unlimited).
REQ-002 SHALL have parameter HOLD_W, default 16, width of the hold counter.
REQ-003 SHALL have clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have req  input  3  bus requests: bit0 = init, bit1 = scene, bit2 = player.
REQ-006 SHALL have data0/data1/data2  input  8 each  requester byte to send.
REQ-007 SHALL have dc_in  input  3  per-requester data/command flag.
REQ-008 SHALL have tx_in  input  3  per-requester transmit strobe.
REQ-009 SHALL have spi_busy  input  1  busy flag from the SPI transmitter.
REQ-010 SHALL have gnt  output  3  one-hot grant, or all-zero.
REQ-011 SHALL have spi_data  output  8  byte to the SPI transmitter.
REQ-012 SHALL have spi_dc  output  1  dc to the SPI transmitter.
REQ-013 SHALL have spi_transmit  output  1  transmit strobe to the SPI transmitter.
REQ-014 SHALL have init_done  output  1  set after the first completed init ownership.
REQ-015 SHALL have timeout  output  1  one-cycle pulse on forced revocation.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, DRAIN and GAP.
REQ-017 IDLE: when any eligible request is present, SHALL latch the winner, assert its gnt on the next cycle and enter GRANT.
- Grant latency: 1 cycle from req to gnt.
REQ-018 Eligibility while init_done = 0: only req[0] is eligible; req[1] and req[2] SHALL be ignored.
REQ-019 Eligibility once init_done = 1: req[0] has fixed top priority; req[1] and req[2] SHALL be served round-robin.
- A one-bit pointer selects the preferred requester; it toggles to the other one whenever requester 1 or 2 is granted.
- The pointer resets to prefer requester 1 (scene).
REQ-020 Mux outputs in GRANT: spi_data, spi_dc and spi_transmit SHALL be the owner's data, dc_in and tx_in bits, combinationally.
REQ-021 Mux outputs in all other states: spi_transmit SHALL be 0, and spi_data and spi_dc SHALL be 0.
REQ-022 GRANT exit on release: when the owner's req is 0, gnt SHALL clear on the next edge and the FSM SHALL enter DRAIN.
REQ-023 A tx_in pulse coincident with the release cycle SHALL still be forwarded.
REQ-024 DRAIN: the FSM SHALL remain in DRAIN while spi_busy = 1 and SHALL enter GAP when spi_busy = 0.
REQ-025 GAP: the FSM SHALL wait one cycle and return to IDLE.
- Earliest re-grant is 3 cycles after req drops, given spi_busy = 0.
REQ-026 init_done SHALL set on the GRANT->DRAIN transition when the owner is requester 0, and SHALL stay set until rst.
REQ-027 Hold counter: SHALL clear on entry to GRANT and increment each GRANT cycle, saturating at all-ones.
REQ-028 Forced revocation: when MAX_HOLD != 0 and the count reaches MAX_HOLD-1 while req is still held, the FSM SHALL enter DRAIN, clear gnt and pulse timeout for exactly one cycle.
REQ-029 A revoked requester SHALL be masked from eligibility until it deasserts req for at least one cycle.
- Revocation of requester 0 SHALL NOT set init_done.
REQ-030 Simultaneous release and revocation in the same cycle SHALL count as a release: no timeout pulse and no mask.
REQ-031 gnt SHALL never have more than one bit set, and SHALL be 0 in every state except GRANT.
REQ-032 Changes on req of non-owners during GRANT, DRAIN or GAP SHALL have no effect until IDLE.

Reset
REQ-033 While rst = 1 at a clk edge, the block SHALL enter IDLE and drive gnt = 0, spi_transmit = 0, spi_data = 0, spi_dc = 0, init_done = 0 and timeout = 0.
- Reset also clears the round-robin pointer to requester 1, the hold counter and the revocation mask.
REQ-034 rst asserted mid-GRANT SHALL drop gnt at that edge, with no DRAIN and no timeout pulse.

Verification
REQ-035 Init gating: req = 3'b110 from reset -> gnt stays 0; then req[0] = 1 at cycle 10 -> gnt = 3'b001 at cycle 11, and init_done stays 0 until release.
REQ-036 Round-robin: init_done = 1 and req = 3'b110 held continuously, each owner releasing after 4 cycles -> grants alternate 010, 100, 010, ... with a gap of at least 3 cycles between grants.
REQ-037 Drain: the owner drops req while spi_busy = 1 for 20 more cycles -> gnt = 0 next cycle, no new grant until 2 cycles after spi_busy falls, and spi_transmit = 0 throughout.
REQ-038 Revocation: MAX_HOLD = 8 and requester 2 holds req -> gnt[2] falls after 8 GRANT cycles, timeout = 1 for one cycle, and requester 2 is not re-granted until req[2] toggles low.
REQ-039 Preemption order: in IDLE with init_done = 1 and req = 3'b111 -> gnt = 3'b001; rst pulsed mid-grant -> gnt = 0 and init_done = 0 on the next edge.
